// File: rtl/imm_build_seq.sv
// imm_build_seq: assembles a 64-bit constant from 1..4 16-bit immediate chunks.
// The first chunk is sign-extended; later chunks shift in from the right.
// The finished constant is offered on a valid/ready output port.
module imm_build_seq #(
  parameter int unsigned CHUNK_W = 16,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CNT_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_chunks,
  output logic               start_ready,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] in_chunk,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  input  logic               flush,
  output logic               busy
);

  // One extra bit so n_chunks+1 (up to 4) fits without wrapping.
  localparam int unsigned RemW = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StOut} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [RemW-1:0]     remaining_q, remaining_d;
  logic                first_q, first_d;

  logic [DATA_W-1:0]   chunk_sext;
  logic [DATA_W-1:0]   chunk_shift;

  assign chunk_sext  = {{(DATA_W-CHUNK_W){in_chunk[CHUNK_W-1]}}, in_chunk};
  assign chunk_shift = {acc_q[DATA_W-CHUNK_W-1:0], in_chunk};

  // State register, accumulator and chunk counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      remaining_q <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
    end
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    if (flush) begin
      state_d     = StIdle;
      acc_d       = '0;
      remaining_d = '0;
      first_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StCollect;
            remaining_d = RemW'(n_chunks) + RemW'(1);
            first_d     = 1'b1;
          end
        end
        StCollect: begin
          if (in_valid) begin
            acc_d   = first_q ? chunk_sext : chunk_shift;
            first_d = 1'b0;
            if (remaining_q != '0) begin
              remaining_d = remaining_q - RemW'(1);
            end
            if (remaining_q == RemW'(1)) begin
              state_d = StOut;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    busy        = (state_q != StIdle);
    start_ready = ~busy;
    in_ready    = (state_q == StCollect);
    out_valid   = (state_q == StOut);
    out_data    = acc_q;
  end

endmodule

// File: tb/tb_imm_build_seq.sv
// Scoreboard bench for imm_build_seq: stimulus pushes expected constants,
// a negedge monitor pops and compares on each output handshake.
module tb_imm_build_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  n_chunks;
  logic        start_ready;
  logic        in_valid;
  logic [15:0] in_chunk;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        flush;
  logic        busy;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  imm_build_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_chunks   (n_chunks),
    .start_ready(start_ready),
    .in_valid   (in_valid),
    .in_chunk   (in_chunk),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: compare every accepted output against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_data, 64'hx);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_start(input logic [1:0] n);
    start    = 1'b1;
    n_chunks = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [15:0] c, input int gap);
    in_valid = 1'b1;
    in_chunk = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      check("gap_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  // k chunks right-aligned in ch, most-significant chunk first.
  task automatic build(input int k, input logic [63:0] ch, input int gap,
                       input logic [63:0] exp);
    exp_q.push_back(exp);
    do_start(2'(k - 1));
    check("collect_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < k; i++) begin
      if (i == k - 1) begin
        check("pre_last_out_valid", {63'd0, out_valid}, 64'd0);
        send_chunk(ch[16*(k-1-i) +: 16], 0);
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
      end else begin
        send_chunk(ch[16*(k-1-i) +: 16], gap);
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !start_ready; i++) @(negedge clk);
    check("return_to_idle", {63'd0, start_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    n_chunks  = 2'd0;
    in_valid  = 1'b0;
    in_chunk  = 16'h0;
    out_ready = 1'b1;
    flush     = 1'b0;
    #12;
    check("rst_out_valid",   {63'd0, out_valid},   64'd0);
    check("rst_out_data",    out_data,             64'd0);
    check("rst_in_ready",    {63'd0, in_ready},    64'd0);
    check("rst_start_ready", {63'd0, start_ready}, 64'd1);
    check("rst_busy",        {63'd0, busy},        64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single chunk: pure sign extension.
    build(1, 64'h8000, 0, 64'hFFFF_FFFF_FFFF_8000);
    wait_idle();
    build(1, 64'h7FFF, 0, 64'h0000_0000_0000_7FFF);
    wait_idle();
    // Two chunks.
    build(2, 64'h8000_1234, 0, 64'hFFFF_FFFF_8000_1234);
    wait_idle();
    build(2, 64'h7FFF_ABCD, 0, 64'h0000_0000_7FFF_ABCD);
    wait_idle();
    // Four chunks with 2-cycle in_valid gaps; sign bits fully shifted out.
    build(4, 64'h1234_5678_9ABC_DEF0, 2, 64'h1234_5678_9ABC_DEF0);
    wait_idle();
    build(4, 64'hF000_0000_0000_0001, 0, 64'hF000_0000_0000_0001);
    wait_idle();

    // Output back-pressure with start pulsed while in OUT.
    out_ready = 1'b0;
    build(1, 64'h00AA, 0, 64'h0000_0000_0000_00AA);
    for (int i = 0; i < 3; i++) begin
      start    = 1'b1;
      n_chunks = 2'd3;
      check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check("stall_out_data",  out_data,           64'h0000_0000_0000_00AA);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("stall_busy", {63'd0, busy}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_start_ready", {63'd0, start_ready}, 64'd1);
    check("hs_out_valid",   {63'd0, out_valid},   64'd0);
    check("hs_in_ready",    {63'd0, in_ready},    64'd0);
    check("hs_data_kept",   out_data,             64'h0000_0000_0000_00AA);
    @(posedge clk);
    #1;

    // Flush after 2 of 3 chunks; a chunk offered with flush is dropped.
    do_start(2'd2);
    send_chunk(16'h1111, 0);
    send_chunk(16'h2222, 0);
    in_valid = 1'b1;
    in_chunk = 16'h3333;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_start_ready", {63'd0, start_ready}, 64'd1);
    check("flush_out_valid",   {63'd0, out_valid},   64'd0);
    check("flush_acc_clear",   out_data,             64'd0);
    build(1, 64'hFFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();

    // Asynchronous reset mid-COLLECT, asserted and released off the edge.
    do_start(2'd1);
    send_chunk(16'h5555, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",    {63'd0, in_ready},    64'd0);
    check("arst_start_ready", {63'd0, start_ready}, 64'd1);
    check("arst_busy",        {63'd0, busy},        64'd0);
    check("arst_out_valid",   {63'd0, out_valid},   64'd0);
    check("arst_out_data",    out_data,             64'd0);
    #7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    build(1, 64'h0001, 0, 64'h0000_0000_0000_0001);
    wait_idle();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
